output_word_sequencer: RTL and testbench

- Parametrised successor to the combinational word-select decoder; replaces the externally driven 4-bit word index with an internal sequencer.
- Captures one wide hash result (WORDS x WORD_W bits) and streams it out one word per handshake.
- For each word it drives a one-hot word_select, the binary index, the word data and a last flag.
- Sits between the hash core result register and the host/UART output path.

---
 rtl/output_seq_pkg.sv | 22 ++
 rtl/onehot_decode.sv | 20 ++
 rtl/output_word_sequencer.sv | 106 ++++++++++
 tb/tb_output_word_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/output_seq_pkg.sv
// Shared types and helpers for the output word sequencer.
package output_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int unsigned ONEHOT_MAX = 256;

    // One-hot of idx over n bits; zero when idx is out of range.
    function automatic logic [ONEHOT_MAX-1:0] onehot_of(input int unsigned idx,
                                                        input int unsigned n);
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if (idx < n && idx < ONEHOT_MAX) begin
            v = ONEHOT_MAX'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Generic binary-to-one-hot decoder with enable; all-zero when disabled.
module onehot_decode
    import output_seq_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = N'(onehot_of(32'(idx), N));
        end
    end

endmodule

// File: rtl/output_word_sequencer.sv
// Captures one WORDS x WORD_W result and streams it out one word per
// valid/ready handshake, with index, one-hot select, last flag and done pulse.
module output_word_sequencer
    import output_seq_pkg::*;
#(
    parameter int unsigned WORDS     = 16,
    parameter int unsigned WORD_W    = 64,
    parameter int unsigned IDX_W     = $clog2(WORDS),
    parameter bit          MSW_FIRST = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [WORDS*WORD_W-1:0] load_data_i,
    output logic                    load_ready_o,
    input  logic                    abort_i,
    output logic                    word_valid_o,
    input  logic                    word_ready_i,
    output logic [WORD_W-1:0]       word_data_o,
    output logic [IDX_W-1:0]        word_idx_o,
    output logic [WORDS-1:0]        word_select_o,
    output logic                    word_last_o,
    output logic                    done_o
);

    localparam int unsigned BUF_W     = WORDS * WORD_W;
    localparam int unsigned FIRST_OFF = MSW_FIRST ? (WORDS - 1) * WORD_W : 0;
    localparam logic [IDX_W-1:0] FIRST_IDX = MSW_FIRST ? IDX_W'(WORDS - 1) : IDX_W'(0);
    localparam logic [IDX_W-1:0] LAST_IDX  = MSW_FIRST ? IDX_W'(0) : IDX_W'(WORDS - 1);

    state_t             state_q, state_n;
    logic [BUF_W-1:0]   buf_q, buf_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [IDX_W-1:0]   idx_step;
    logic [WORD_W-1:0]  data_q, data_n;
    logic               done_q, done_n;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            buf_q   <= buf_n;
            idx_q   <= idx_n;
            data_q  <= data_n;
            done_q  <= done_n;
        end
    end

    // Next-state: the final word holds the counter so it never leaves 0..WORDS-1
    always_comb begin
        state_n  = state_q;
        buf_n    = buf_q;
        idx_n    = idx_q;
        data_n   = data_q;
        done_n   = 1'b0;
        idx_step = MSW_FIRST ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);

        case (state_q)
            IDLE: begin
                if (load_i && !abort_i) begin
                    buf_n   = load_data_i;
                    idx_n   = FIRST_IDX;
                    data_n  = load_data_i[FIRST_OFF +: WORD_W];
                    state_n = SEND;
                end
            end
            SEND: begin
                if (abort_i) begin
                    state_n = IDLE;
                end else if (word_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n  = idx_step;
                        data_n = buf_q[32'(idx_step) * WORD_W +: WORD_W];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign load_ready_o = (state_q == IDLE);
    assign word_valid_o = (state_q == SEND);
    assign word_idx_o   = idx_q;
    assign word_data_o  = data_q;
    assign word_last_o  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign done_o       = done_q;

    onehot_decode #(
        .N     (WORDS),
        .IDX_W (IDX_W)
    ) u_select (
        .idx    (idx_q),
        .en     (state_q == SEND),
        .onehot (word_select_o)
    );

endmodule

// File: tb/tb_output_word_sequencer.sv
// Scoreboard bench: three sequencer configurations share stimulus and are
// checked against a queue-based model of the word stream.
module tb_output_word_sequencer;

    localparam int NW [3] = '{16, 16, 5};
    localparam bit MS [3] = '{1'b0, 1'b1, 1'b0};

    typedef struct {
        int          idx;
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, load, abort, ready;
    logic [1023:0] load_data;

    logic        lr0, v0, last0, done0;
    logic [3:0]  idx0;
    logic [63:0] data0;
    logic [15:0] sel0;
    logic        lr1, v1, last1, done1;
    logic [3:0]  idx1;
    logic [63:0] data1;
    logic [15:0] sel1;
    logic        lr2, v2, last2, done2;
    logic [2:0]  idx2;
    logic [63:0] data2;
    logic [4:0]  sel2;

    output_word_sequencer #(.WORDS(16), .WORD_W(64), .IDX_W(4), .MSW_FIRST(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .load_i(load), .load_data_i(load_data),
        .load_ready_o(lr0), .abort_i(abort), .word_valid_o(v0), .word_ready_i(ready),
        .word_data_o(data0), .word_idx_o(idx0), .word_select_o(sel0),
        .word_last_o(last0), .done_o(done0));

    output_word_sequencer #(.WORDS(16), .WORD_W(64), .IDX_W(4), .MSW_FIRST(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .load_i(load), .load_data_i(load_data),
        .load_ready_o(lr1), .abort_i(abort), .word_valid_o(v1), .word_ready_i(ready),
        .word_data_o(data1), .word_idx_o(idx1), .word_select_o(sel1),
        .word_last_o(last1), .done_o(done1));

    output_word_sequencer #(.WORDS(5), .WORD_W(64), .IDX_W(3), .MSW_FIRST(1'b0)) dut2 (
        .clk_i(clk), .rst_i(rst), .load_i(load), .load_data_i(load_data[319:0]),
        .load_ready_o(lr2), .abort_i(abort), .word_valid_o(v2), .word_ready_i(ready),
        .word_data_o(data2), .word_idx_o(idx2), .word_select_o(sel2),
        .word_last_o(last2), .done_o(done2));

    logic [2:0]  o_lr, o_valid, o_last, o_done;
    logic [3:0]  o_idx  [3];
    logic [63:0] o_data [3];
    logic [15:0] o_sel  [3];

    assign o_lr    = {lr2, lr1, lr0};
    assign o_valid = {v2, v1, v0};
    assign o_last  = {last2, last1, last0};
    assign o_done  = {done2, done1, done0};
    assign o_idx[0] = idx0;
    assign o_idx[1] = idx1;
    assign o_idx[2] = {1'b0, idx2};
    assign o_data[0] = data0;
    assign o_data[1] = data1;
    assign o_data[2] = data2;
    assign o_sel[0] = sel0;
    assign o_sel[1] = sel1;
    assign o_sel[2] = {11'b0, sel2};

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string nm, input int d, input logic [63:0] act,
                         input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // Reference model: a loaded result becomes a queue of beats in emission order
    bit    busy      [3] = '{0, 0, 0};
    int    remaining [3] = '{0, 0, 0};
    bit    exp_done  [3] = '{0, 0, 0};
    beat_t exp_q     [3][$];

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            exp_done[d] = 1'b0;
            if (rst) begin
                busy[d] = 1'b0;
                exp_q[d].delete();
            end else if (busy[d]) begin
                if (abort) begin
                    busy[d] = 1'b0;
                    exp_q[d].delete();
                end else if (ready) begin
                    remaining[d]--;
                    if (remaining[d] == 0) begin
                        busy[d]     = 1'b0;
                        exp_done[d] = 1'b1;
                    end
                end
            end else if (load && !abort) begin
                for (int j = 0; j < NW[d]; j++) begin
                    beat_t b;
                    b.idx  = MS[d] ? NW[d] - 1 - j : j;
                    b.data = load_data[b.idx*64 +: 64];
                    b.last = (j == NW[d] - 1);
                    exp_q[d].push_back(b);
                end
                busy[d]      = 1'b1;
                remaining[d] = NW[d];
            end
        end
    end

    // Monitor: compares presented outputs and pops on each handshake
    bit          mon_en = 1'b0;
    bit          rst_prev = 1'b1;
    int          hold_idx  [3] = '{0, 0, 0};
    logic [63:0] hold_data [3] = '{64'd0, 64'd0, 64'd0};

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (rst_prev) begin
                    hold_idx[d]  = 0;
                    hold_data[d] = 64'd0;
                    check("reset_last", d, 64'(o_last[d]), 64'd0);
                end
                check("load_ready", d, 64'(o_lr[d]), 64'(!busy[d]));
                check("valid", d, 64'(o_valid[d]), 64'(busy[d]));
                check("done", d, 64'(o_done[d]), 64'(exp_done[d]));
                if (busy[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check("queue_underflow", d, 64'd1, 64'd0);
                    end else begin
                        beat_t b;
                        b = exp_q[d][0];
                        check("idx", d, 64'(o_idx[d]), 64'(b.idx));
                        check("data", d, o_data[d], b.data);
                        check("last", d, 64'(o_last[d]), 64'(b.last));
                        check("select", d, 64'(o_sel[d]), 64'(16'd1 << b.idx));
                        check("idx_range", d, 64'(int'(o_idx[d]) < NW[d]), 64'd1);
                        hold_idx[d]  = b.idx;
                        hold_data[d] = b.data;
                        if (ready && !rst) void'(exp_q[d].pop_front());
                    end
                end else begin
                    check("idle_select", d, 64'(o_sel[d]), 64'd0);
                    check("idle_idx", d, 64'(o_idx[d]), 64'(hold_idx[d]));
                    check("idle_data", d, o_data[d], hold_data[d]);
                end
            end
            rst_prev = rst;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int w = 0; w < 16; w++) load_data[w*64 +: 64] = {$urandom, $urandom};
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; abort = 1'b0; ready = 1'b0; load_data = '0;
        cyc();
        mon_en = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();

        // Basic stream with ready held high
        for (int k = 0; k < 16; k++) load_data[k*64 +: 64] = 64'h1000_0000_0000_0000 + 64'(k);
        load = 1'b1; cyc(); load = 1'b0;
        ready = 1'b1;
        repeat (20) cyc();

        // Backpressure pattern 1,0,0
        rand_data();
        load = 1'b1; cyc(); load = 1'b0;
        for (int i = 0; i < 60; i++) begin
            ready = (i % 3 == 0);
            cyc();
        end

        // Abort at idx 7, then reload
        rand_data();
        load = 1'b1; cyc(); load = 1'b0;
        ready = 1'b1;
        repeat (7) cyc();
        abort = 1'b1; cyc(); abort = 1'b0;
        cyc();
        rand_data();
        load = 1'b1; cyc(); load = 1'b0;
        repeat (20) cyc();

        // Load held during SEND, then reset at idx 3
        rand_data();
        load = 1'b1; ready = 1'b1;
        repeat (4) cyc();
        rst = 1'b1; cyc(); rst = 1'b0; load = 1'b0;
        repeat (3) cyc();

        // Abort together with load in IDLE: load is dropped
        abort = 1'b1; load = 1'b1; cyc();
        abort = 1'b0; load = 1'b0;
        repeat (2) cyc();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            load  = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            if (load) rand_data();
            cyc();
        end

        // Drain and confirm every expected beat was seen
        rst = 1'b0; load = 1'b0; abort = 1'b0; ready = 1'b1;
        repeat (30) cyc();
        for (int d = 0; d < 3; d++) check("drain_empty", d, 64'(exp_q[d].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
